vga_ctrl: RTL and testbench
===========================

VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_SYNC, 96, horizontal sync width in vga_clk cycles.
REQ-002 Parameter H_BACK, 48, horizontal back porch in cycles.
REQ-003 Parameter H_VALID, 640, active pixels per line.
REQ-004 Parameter H_FRONT, 16, horizontal front porch in cycles.
REQ-005 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-006 Parameter V_BACK, 33, vertical back porch in lines.
REQ-007 Parameter V_VALID, 480, active lines per frame.
REQ-008 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-009 Port vga_clk, input, 1, pixel clock (25 MHz nominal); all logic on its rising edge.
REQ-010 Port sys_rst, input, 1, synchronous active-high reset.
REQ-011 Port pix_data, input, 16, RGB565 from pixel source; valid one cycle after the coordinate request.
REQ-012 Port pix_x, output, 10, requested column; 10'h3FF when no request.
REQ-013 Port pix_y, output, 10, requested row; 10'h3FF when no request.
REQ-014 Port hsync, output, 1, horizontal sync; high during sync interval.
REQ-015 Port vsync, output, 1, vertical sync; high during sync interval.
REQ-016 Port rgb_valid, output, 1, high when rgb carries an active pixel.
REQ-017 Port rgb, output, 16, pixel to display.

Function
REQ-018 The block SHALL hold registers cnt_h counting 0..H_TOTAL-1 (H_TOTAL = sum of H parameters) and cnt_v counting 0..V_TOTAL-1 (V_TOTAL = sum of V parameters).
REQ-019 cnt_h SHALL wrap to 0 after H_TOTAL-1; cnt_v SHALL advance only on that wrap cycle and wrap to 0 after V_TOTAL-1, with both wraps occurring on the same edge at frame end.
REQ-020 hsync SHALL be 1 iff cnt_h < H_SYNC; vsync SHALL be 1 iff cnt_v < V_SYNC.
REQ-021 With HA = H_SYNC+H_BACK and VA = V_SYNC+V_BACK, rgb_valid SHALL be 1 iff HA <= cnt_h < HA+H_VALID and VA <= cnt_v < VA+V_VALID.
REQ-022 Request window: pix_req is 1 iff HA-1 <= cnt_h < HA+H_VALID-1 and cnt_v is in the active rows, so the request leads rgb_valid by exactly one cycle.
REQ-023 While pix_req is 1, pix_x SHALL be cnt_h-(HA-1) and pix_y SHALL be cnt_v-VA; otherwise both SHALL be 10'h3FF.
REQ-024 rgb SHALL equal pix_data while rgb_valid is 1 and 16'h0000 otherwise, with no further registering.
REQ-025 Outputs SHALL be decoded from registered counters only; no combinational path from pix_data except into rgb.
REQ-026 Counter arithmetic SHALL be 10 bits wide; parameter sums SHALL not exceed 1023.

Reset
REQ-027 While sys_rst is 1 at a clock edge, cnt_h and cnt_v SHALL load 0, regardless of position in the frame.
REQ-028 During and immediately after reset: hsync=1, vsync=1, rgb_valid=0, rgb=0, pix_x=pix_y=10'h3FF.
REQ-029 A reset asserted mid-line or mid-frame SHALL restart timing from cnt_h=0, cnt_v=0 on the first edge after release, with no partial line emitted.

Configuration
REQ-030 When macro VGA_CTRL_FRAME_CNT_EN is defined, the block SHALL add output frame_cnt (16 bits), cleared by reset and incremented, wrapping modulo 65536, on the edge where cnt_h and cnt_v both wrap.
REQ-031 When VGA_CTRL_FRAME_CNT_EN is undefined, the frame_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 Release reset, default parameters -> hsync high for 96 cycles, low for 704; line period is 800 cycles.
REQ-033 Frame scan -> vsync high for 2 lines (1600 cycles); frame period is 420000 cycles; first rgb_valid at cnt_h=144, cnt_v=35.
REQ-034 Request timing -> pix_x=0, pix_y=0 at cnt_h=143, cnt_v=35; pix_x=639 at cnt_h=782; pix_x=10'h3FF at cnt_h=783.
REQ-035 Source returns 16'hF800 registered from pix_x/pix_y -> rgb=16'hF800 exactly when rgb_valid=1, and 0 in porches and sync.
REQ-036 Assert sys_rst for 3 cycles at cnt_v=200, cnt_h=400 -> counters read 0, outputs follow REQ-028, and the next frame timing matches REQ-032/033.
REQ-037 VGA_CTRL_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 0, 1, 2, 3 at successive frame wraps; with the macro undefined, the build elaborates with no frame_cnt port.

Source files
------------

// File: rtl/vga_ctrl_if.sv
// vga_ctrl_if: pixel request/response and display timing bundle between vga_ctrl and its pixel source/display.
interface vga_ctrl_if;
  logic [15:0] pix_data;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic hsync;
  logic vsync;
  logic rgb_valid;
  logic [15:0] rgb;
  modport master (input pix_data, output pix_x, pix_y, hsync, vsync, rgb_valid, rgb);
  modport slave (output pix_data, input pix_x, pix_y, hsync, vsync, rgb_valid, rgb);
endinterface

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator issuing pixel requests one cycle ahead of display.
// Define VGA_CTRL_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_ctrl #(
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input logic vga_clk,
  input logic sys_rst,
  vga_ctrl_if.master bus
`ifdef VGA_CTRL_FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);
  localparam logic [9:0] HS = 10'(H_SYNC);
  localparam logic [9:0] VS = 10'(V_SYNC);
  localparam logic [9:0] HA = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] VA = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] HE = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] VE = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0] HL = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [9:0] VL = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  logic [9:0] r_cnt_h;
  logic [9:0] r_cnt_v;
  logic w_h_end;
  logic w_v_end;
  logic w_v_act;
  logic w_req;
  assign w_h_end = r_cnt_h == HL;
  assign w_v_end = r_cnt_v == VL;
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else begin
      r_cnt_h <= w_h_end ? '0 : r_cnt_h + 10'd1;
      if (w_h_end) r_cnt_v <= w_v_end ? '0 : r_cnt_v + 10'd1;
    end
  end
  // requests run one column ahead so the registered source answer lands on the displayed pixel
  assign w_v_act = r_cnt_v >= VA && r_cnt_v < VE;
  assign w_req = w_v_act && r_cnt_h >= HA - 10'd1 && r_cnt_h < HE - 10'd1;
  assign bus.hsync = r_cnt_h < HS;
  assign bus.vsync = r_cnt_v < VS;
  assign bus.rgb_valid = w_v_act && r_cnt_h >= HA && r_cnt_h < HE;
  assign bus.pix_x = w_req ? r_cnt_h - (HA - 10'd1) : 10'h3FF;
  assign bus.pix_y = w_req ? r_cnt_v - VA : 10'h3FF;
  assign bus.rgb = bus.rgb_valid ? bus.pix_data : 16'h0000;
`ifdef VGA_CTRL_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge vga_clk) begin
    if (sys_rst) r_frame_cnt <= '0;
    else if (w_h_end && w_v_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: randomized self-checking bench for vga_ctrl using a cycle-position reference model.
module tb_vga_ctrl;
  localparam int HS = 5, HB = 3, HV = 10, HF = 2;
  localparam int VS = 2, VB = 3, VV = 6, VF = 2;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FRAME = HT * VT;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;
  typedef struct packed {
    logic hs;
    logic vs;
    logic val;
    logic [9:0] px;
    logic [9:0] py;
    logic [15:0] rgb;
  } obs_t;
  localparam obs_t RST_E = '{hs: 1'b1, vs: 1'b1, val: 1'b0, px: 10'h3FF, py: 10'h3FF, rgb: 16'h0000};
  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic src_const = 1'b0;
  logic [15:0] seed = 16'h0;
  int total = 0;
  int bad = 0;
  vga_ctrl_if bus();
`ifdef VGA_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
  ) dut (
    .vga_clk(vga_clk),
    .sys_rst(sys_rst),
    .bus(bus)
`ifdef VGA_CTRL_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  always #5 vga_clk = ~vga_clk;
  // pixel source: registered answer to the current request
  always @(posedge vga_clk)
    bus.pix_data <= src_const ? 16'hF800 : ({bus.pix_x[7:0], bus.pix_y[7:0]} ^ seed);
  function automatic obs_t model(int t);
    obs_t e;
    int h = t % HT;
    int v = (t / HT) % VT;
    bit act_v = v >= VA && v < VA + VV;
    bit req = act_v && h >= HA - 1 && h < HA + HV - 1;
    e.hs = h < HS;
    e.vs = v < VS;
    e.val = act_v && h >= HA && h < HA + HV;
    e.px = req ? 10'(h - HA + 1) : 10'h3FF;
    e.py = req ? 10'(v - VA) : 10'h3FF;
    e.rgb = !e.val ? 16'h0 : src_const ? 16'hF800 : ({8'(h - HA), 8'(v - VA)} ^ seed);
    return e;
  endfunction
  function automatic obs_t observed();
    obs_t o;
    o.hs = bus.hsync;
    o.vs = bus.vsync;
    o.val = bus.rgb_valid;
    o.px = bus.pix_x;
    o.py = bus.pix_y;
    o.rgb = bus.rgb;
    return o;
  endfunction
  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask
  task automatic do_reset(int n);
    sys_rst = 1'b1;
    repeat (n) step();
    sys_rst = 1'b0;
  endtask
  task automatic test_reset();
    obs_t o;
    sys_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      o = observed();
      total++;
      if (o !== RST_E) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, RST_E);
      end
    end
    sys_rst = 1'b0;
    o = observed();
    total++;
    if (o !== RST_E) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", o, RST_E);
    end
`ifdef VGA_CTRL_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt);
    end
`endif
  endtask
  task automatic test_frame_scan(int frames, bit cst);
    obs_t o, e;
    seed = 16'($urandom);
    src_const = cst;
    do_reset(int'($urandom_range(1, 3)));
    for (int t = 0; t < frames * FRAME + HT; t++) begin
      o = observed();
      e = model(t);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL scan cst=%0b t=%0d got hs=%b vs=%b val=%b px=%h py=%h rgb=%h exp hs=%b vs=%b val=%b px=%h py=%h rgb=%h",
                 cst, t, o.hs, o.vs, o.val, o.px, o.py, o.rgb, e.hs, e.vs, e.val, e.px, e.py, e.rgb);
      end
      step();
    end
    src_const = 1'b0;
  endtask
  task automatic test_sync_widths();
    int hs_n = 0, vs_n = 0, val_n = 0, first = -1;
    do_reset(1);
    for (int t = 0; t < FRAME; t++) begin
      hs_n += int'(bus.hsync);
      vs_n += int'(bus.vsync);
      val_n += int'(bus.rgb_valid);
      if (bus.rgb_valid === 1'b1 && first < 0) first = t;
      step();
    end
    total += 4;
    if (hs_n != HS * VT) begin bad++; $display("FAIL hsync_width got=%0d exp=%0d", hs_n, HS * VT); end
    if (vs_n != VS * HT) begin bad++; $display("FAIL vsync_width got=%0d exp=%0d", vs_n, VS * HT); end
    if (val_n != HV * VV) begin bad++; $display("FAIL valid_count got=%0d exp=%0d", val_n, HV * VV); end
    if (first != VA * HT + HA) begin bad++; $display("FAIL first_valid got=%0d exp=%0d", first, VA * HT + HA); end
  endtask
  task automatic test_request_timing();
    do_reset(1);
    repeat (VA * HT + HA - 1) step();
    total++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 10'd0 || bus.rgb_valid !== 1'b0) begin
      bad++;
      $display("FAIL req_first got x=%h y=%h val=%b exp x=000 y=000 val=0", bus.pix_x, bus.pix_y, bus.rgb_valid);
    end
    step();
    total++;
    if (bus.pix_x !== 10'd1 || bus.rgb_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_second got x=%h val=%b exp x=001 val=1", bus.pix_x, bus.rgb_valid);
    end
    repeat (HV - 2) step();
    total++;
    if (bus.pix_x !== 10'(HV - 1) || bus.pix_y !== 10'd0) begin
      bad++;
      $display("FAIL req_last got x=%h y=%h exp x=%h y=000", bus.pix_x, bus.pix_y, 10'(HV - 1));
    end
    step();
    total++;
    if (bus.pix_x !== 10'h3FF || bus.pix_y !== 10'h3FF || bus.rgb_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_end got x=%h y=%h val=%b exp x=3ff y=3ff val=1", bus.pix_x, bus.pix_y, bus.rgb_valid);
    end
    step();
    total++;
    if (bus.rgb_valid !== 1'b0 || bus.rgb !== 16'h0) begin
      bad++;
      $display("FAIL valid_end got val=%b rgb=%h exp val=0 rgb=0000", bus.rgb_valid, bus.rgb);
    end
  endtask
  task automatic test_mid_reset();
    obs_t o, e;
    int n;
    seed = 16'($urandom);
    do_reset(1);
    repeat ($urandom_range(HT, FRAME - 1)) step();
    sys_rst = 1'b1;
    n = int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) begin
      step();
      o = observed();
      total++;
      if (o !== RST_E) begin
        bad++;
        $display("FAIL mid_reset_hold cyc=%0d got=%h exp=%h", i, o, RST_E);
      end
    end
    sys_rst = 1'b0;
`ifdef VGA_CTRL_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset_frame_cnt got=%0d exp=0", frame_cnt);
    end
`endif
    for (int t = 0; t < FRAME + HT; t++) begin
      o = observed();
      e = model(t);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL mid_reset_scan t=%0d got=%h exp=%h", t, o, e);
      end
      step();
    end
  endtask
`ifdef VGA_CTRL_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset(2);
    for (int t = 0; t <= 3 * FRAME; t++) begin
      if (t % FRAME == 0 || t % FRAME == FRAME - 1) begin
        total++;
        if (frame_cnt !== 16'(t / FRAME)) begin
          bad++;
          $display("FAIL frame_cnt t=%0d got=%0d exp=%0d", t, frame_cnt, t / FRAME);
        end
      end
      step();
    end
  endtask
`endif
  initial begin
    test_reset();
    test_frame_scan(2, 1'b0);
    test_frame_scan(1, 1'b1);
    test_sync_widths();
    test_request_timing();
    test_mid_reset();
    test_mid_reset();
`ifdef VGA_CTRL_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
